// File: rtl/seq_det_pkg.sv
// Shared constants, types and parameter checks for the serial pattern detector.
package seq_det_pkg;

    localparam int unsigned PAT_W_MIN     = 2;
    localparam int unsigned PAT_W_MAX     = 32;
    localparam int unsigned DEFAULT_PAT_W = 4;
    localparam logic [DEFAULT_PAT_W-1:0] DEFAULT_PAT = 4'b1011;

    // What the history/fill state does on a given cycle.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_SHIFT   = 2'd1,
        ACT_RESTART = 2'd2,
        ACT_LOAD    = 2'd3
    } hist_act_e;

    // True when the pattern and counter widths describe a buildable detector.
    function automatic bit params_legal(input int unsigned pat_w, input int unsigned cnt_w);
        return (pat_w >= PAT_W_MIN) && (pat_w <= PAT_W_MAX) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bit-stream, control and result signals of the pattern detector.
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             z;
    logic             z_q;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    // Stream source and consumer of the match results.
    modport master (
        output x, x_valid, overlap, pat_load, pat_in, cnt_clr,
        input  z, z_q, match_cnt, cnt_sat
    );

    // The detector itself.
    modport slave (
        input  x, x_valid, overlap, pat_load, pat_in, cnt_clr,
        output z, z_q, match_cnt, cnt_sat
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    // Stops at all ones so the count never wraps.
    assign sat = &q;

    // Count register: clear first, then increment unless already saturated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !sat) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with Mealy match output and match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0]     RST_PAT = PAT_W'(DEFAULT_PAT),
    parameter int unsigned          CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    // Reject illegal widths at elaboration.
    if (!params_legal(PAT_W, CNT_W)) begin : g_bad_params
        $error("seq_detector_param: PAT_W must be 2..32 and CNT_W at least 1");
    end

    logic [PAT_W-1:0]  pat, pat_nxt;
    logic [HIST_W-1:0] hist, hist_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic              z_q;
    logic [PAT_W-1:0]  cand;
    logic              z_c;
    hist_act_e         act;

    // Match compare: history plus the current bit against the pattern, only once history is full.
    always_comb begin
        cand = {hist, bus.x};
        z_c  = bus.x_valid && !bus.pat_load && (fill == FILL_FULL) && (cand == pat);
    end

    // Decide what the history does this cycle; a load overrides any stream bit.
    always_comb begin
        act = ACT_HOLD;
        if (bus.pat_load) begin
            act = ACT_LOAD;
        end else if (!bus.x_valid) begin
            act = ACT_HOLD;
        end else if (z_c && !bus.overlap) begin
            act = ACT_RESTART;
        end else begin
            act = ACT_SHIFT;
        end
    end

    // Next-state of pattern, history and fill count.
    always_comb begin
        pat_nxt  = pat;
        hist_nxt = hist;
        fill_nxt = fill;
        case (act)
            ACT_SHIFT: begin
                hist_nxt = cand[HIST_W-1:0];
                fill_nxt = (fill == FILL_FULL) ? fill : FILL_W'(fill + FILL_W'(1));
            end
            ACT_RESTART: begin
                hist_nxt = '0;
                fill_nxt = '0;
            end
            ACT_LOAD: begin
                pat_nxt  = bus.pat_in;
                hist_nxt = '0;
                fill_nxt = '0;
            end
            default: begin
                pat_nxt  = pat;
                hist_nxt = hist;
                fill_nxt = fill;
            end
        endcase
    end

    // State registers and the registered copy of the match flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat  <= RST_PAT;
            hist <= '0;
            fill <= '0;
            z_q  <= 1'b0;
        end else begin
            pat  <= pat_nxt;
            hist <= hist_nxt;
            fill <= fill_nxt;
            z_q  <= z_c;
        end
    end

    assign bus.z   = z_c;
    assign bus.z_q = z_q;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (z_c),
        .clr (bus.cnt_clr),
        .q   (bus.match_cnt),
        .sat (bus.cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed vector bench for seq_detector_param (4-bit pattern, 2-bit counter).
module tb_seq_detector_param;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 2;

    typedef struct {
        logic             x;
        logic             x_valid;
        logic             overlap;
        logic             pat_load;
        logic [PAT_W-1:0] pat_in;
        logic             cnt_clr;
        logic             exp_z;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bif ();

    seq_detector_param #(
        .PAT_W   (PAT_W),
        .RST_PAT (4'b1011),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic x, input logic v, input logic ovl, input logic ld,
                                input logic [PAT_W-1:0] pin, input logic clr,
                                input logic ez, input logic [CNT_W-1:0] ecnt);
        vec_t r;
        r.x = x; r.x_valid = v; r.overlap = ovl; r.pat_load = ld;
        r.pat_in = pin; r.cnt_clr = clr; r.exp_z = ez; r.exp_cnt = ecnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector after the edge, check z mid-cycle, check registered results after the next edge.
    task automatic apply(input vec_t v, input string tag);
        bif.x        = v.x;
        bif.x_valid  = v.x_valid;
        bif.overlap  = v.overlap;
        bif.pat_load = v.pat_load;
        bif.pat_in   = v.pat_in;
        bif.cnt_clr  = v.cnt_clr;
        @(negedge clk);
        check({tag, " z"}, 32'(bif.z), 32'(v.exp_z));
        @(posedge clk);
        #1;
        check({tag, " z_q"}, 32'(bif.z_q), 32'(v.exp_z));
        check({tag, " cnt"}, 32'(bif.match_cnt), 32'(v.exp_cnt));
        check({tag, " sat"}, 32'(bif.cnt_sat), 32'(v.exp_cnt == {CNT_W{1'b1}}));
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        total = 0;
        bad = 0;
        bif.x = 1'b0; bif.x_valid = 1'b0; bif.overlap = 1'b1;
        bif.pat_load = 1'b0; bif.pat_in = '0; bif.cnt_clr = 1'b0;

        // Overlapping 1011 on 1,0,1,1,0,1,1
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,1));
        vecs.push_back(mk(0,1,1,0,4'h0,0, 0,1));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,1));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,2));
        // Restart history, clear count; the stream bit is discarded by the load
        vecs.push_back(mk(1,1,1,1,4'b1011,1, 0,0));
        // Non-overlapping on the same stream
        vecs.push_back(mk(1,1,0,0,4'h0,0, 0,0));
        vecs.push_back(mk(0,1,0,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,0,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,0,0,4'h0,0, 1,1));
        vecs.push_back(mk(0,1,0,0,4'h0,0, 0,1));
        vecs.push_back(mk(1,1,0,0,4'h0,0, 0,1));
        vecs.push_back(mk(1,1,0,0,4'h0,0, 0,1));
        vecs.push_back(mk(0,0,1,1,4'b1011,1, 0,0));
        // Gap in the valid stream keeps the partial match
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,0,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,0,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,0,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,1));
        vecs.push_back(mk(0,0,1,1,4'b1011,1, 0,0));
        // Load 0110 after a partial 101; the load-cycle bit would have completed 1011
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,1,4'b0110,0, 0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(0,1,1,0,4'h0,0, 1,1));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,1));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,1));
        // Pattern 1111 on eight 1s: counter saturates at 3
        vecs.push_back(mk(0,0,1,1,4'b1111,1, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 0,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,1));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,2));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,3));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,3));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,3));
        // Clear on a matching cycle wins over the increment
        vecs.push_back(mk(1,1,1,0,4'h0,1, 1,0));
        vecs.push_back(mk(1,1,1,0,4'h0,0, 1,1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset z", 32'(bif.z), 32'd0);
        check("reset z_q", 32'(bif.z_q), 32'd0);
        check("reset cnt", 32'(bif.match_cnt), 32'd0);
        check("reset sat", 32'(bif.cnt_sat), 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Mid-stream reset after loading 0110 and three bits 0,1,1
        apply(mk(0,0,1,1,4'b0110,0, 0,1), "r_load");
        apply(mk(0,1,1,0,4'h0,0, 0,1), "r_b0");
        apply(mk(1,1,1,0,4'h0,0, 0,1), "r_b1");
        apply(mk(1,1,1,0,4'h0,0, 0,1), "r_b2");
        bif.x = 1'b0;
        bif.x_valid = 1'b1;
        rst = 1'b0;
        #1;
        check("midrst z", 32'(bif.z), 32'd0);
        check("midrst z_q", 32'(bif.z_q), 32'd0);
        check("midrst cnt", 32'(bif.match_cnt), 32'd0);
        check("midrst sat", 32'(bif.cnt_sat), 32'd0);
        @(posedge clk);
        #1;
        check("midrst z held", 32'(bif.z), 32'd0);
        rst = 1'b1;
        // Pattern reverts to 1011
        apply(mk(1,1,1,0,4'h0,0, 0,0), "p0");
        apply(mk(0,1,1,0,4'h0,0, 0,0), "p1");
        apply(mk(1,1,1,0,4'h0,0, 0,0), "p2");
        apply(mk(1,1,1,0,4'h0,0, 1,1), "p3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
